// File: rtl/wdog_apb_timer.sv
// APB watchdog timer: down-counter with interrupt on timeout and reset request on an unserviced second timeout.
// Optional write-lock register at 0xC00 is built in when WDOG_LOCK_EN is defined.
module wdog_apb_timer (
    input  logic        apb_clk,
    input  logic        apb_rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic [3:0]  ecorevnum,
    output logic        wdogint,
    output logic        wdogres
);

    localparam logic [9:0]  A_LOAD     = 10'h000;
    localparam logic [9:0]  A_VALUE    = 10'h001;
    localparam logic [9:0]  A_CTRL     = 10'h002;
    localparam logic [9:0]  A_INTCLR   = 10'h003;
    localparam logic [9:0]  A_RIS      = 10'h004;
    localparam logic [9:0]  A_MIS      = 10'h005;
    localparam logic [9:0]  A_LOCK     = 10'h300;
    localparam logic [9:0]  A_ID       = 10'h3F8;
    localparam logic [31:0] UNLOCK_KEY = 32'h1ACCE551;

    logic [31:0] load_q,  load_d;
    logic [31:0] cnt_q,   cnt_d;
    logic        inten_q, inten_d;
    logic        resen_q, resen_d;
    logic        ris_q,   ris_d;
    logic        int_q,   int_d;
    logic        res_q,   res_d;

    logic [9:0]  addr;
    logic        wr_acc;
    logic        rd_acc;
    logic        wr_ok;
    logic        wr_load;
    logic        wr_ctrl;
    logic        wr_intclr;
    logic        timeout;
    logic        unused_addr_bits;

    assign addr             = paddr[11:2];
    assign unused_addr_bits = ^paddr[1:0];
    assign wr_acc           = psel & penable & pwrite;
    assign rd_acc           = psel & penable;

`ifdef WDOG_LOCK_EN
    logic locked_q, locked_d;

    assign wr_ok = ~locked_q;

    always_comb begin
        locked_d = locked_q;
        if (wr_acc && addr == A_LOCK) begin
            locked_d = (pwdata != UNLOCK_KEY);
        end
    end

    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end
`else
    assign wr_ok = 1'b1;
`endif

    assign wr_load   = wr_acc & wr_ok & (addr == A_LOAD);
    assign wr_ctrl   = wr_acc & wr_ok & (addr == A_CTRL);
    assign wr_intclr = wr_acc & wr_ok & (addr == A_INTCLR);
    assign timeout   = inten_q & (cnt_q == 32'h0);

    always_comb begin
        load_d  = load_q;
        inten_d = inten_q;
        resen_d = resen_q;
        if (wr_load) begin
            load_d = pwdata;
        end
        if (wr_ctrl) begin
            inten_d = pwdata[0];
            resen_d = pwdata[1];
        end
    end

    // A reload on timeout or INTCLR always happens before the count could go below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_load) begin
            cnt_d = pwdata;
        end else if (wr_intclr || timeout) begin
            cnt_d = load_q;
        end else if (inten_q) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    // INTCLR beats a coincident timeout, which also suppresses the reset request.
    always_comb begin
        ris_d = ris_q;
        if (wr_intclr) begin
            ris_d = 1'b0;
        end else if (timeout) begin
            ris_d = 1'b1;
        end
        res_d = res_q | (timeout & ris_q & resen_q & ~wr_intclr);
        int_d = ris_d & inten_d;
    end

    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) begin
            load_q  <= 32'hFFFF_FFFF;
            cnt_q   <= 32'hFFFF_FFFF;
            inten_q <= 1'b0;
            resen_q <= 1'b0;
            ris_q   <= 1'b0;
            int_q   <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            inten_q <= inten_d;
            resen_q <= resen_d;
            ris_q   <= ris_d;
            int_q   <= int_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        prdata = 32'h0;
        if (rd_acc) begin
            case (addr)
                A_LOAD:  prdata = load_q;
                A_VALUE: prdata = cnt_q;
                A_CTRL:  prdata = {30'h0, resen_q, inten_q};
                A_RIS:   prdata = {31'h0, ris_q};
                A_MIS:   prdata = {31'h0, ris_q & inten_q};
`ifdef WDOG_LOCK_EN
                A_LOCK:  prdata = {31'h0, locked_q};
`endif
                A_ID:    prdata = {28'h0, ecorevnum};
                default: prdata = 32'h0;
            endcase
        end
    end

    assign pready  = 1'b1;
    assign pslverr = 1'b0;
    assign wdogint = int_q;
    assign wdogres = res_q;

endmodule

// File: doc/wdog_apb_timer.md
WDOG_APB_TIMER -- requirements
Module: wdog_apb_timer

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 apb_clk  input  1  single clock for APB and counter; all state on its rising edge.
REQ-003 apb_rst  input  1  asynchronous, active-high reset.
REQ-004 psel  input  1  APB select.
REQ-005 penable  input  1  APB access phase.
REQ-006 pwrite  input  1  1 = write, 0 = read.
REQ-007 paddr  input  12  byte address; bits [11:2] decoded, [1:0] ignored.
REQ-008 pwdata  input  32  write data.
REQ-009 prdata  output  32  read data, valid in access phase.
REQ-010 pready  output  1  tied 1 (zero wait states).
REQ-011 pslverr  output  1  tied 0.
REQ-012 ecorevnum  input  4  ECO revision, readable in the ID register.
REQ-013 wdogint  output  1  interrupt, level, registered.
REQ-014 wdogres  output  1  watchdog reset request, level, registered.

Function
REQ-015 Writes commit on the rising edge where psel=1, penable=1 and pwrite=1; reads are combinational from the decoded address when psel=1 and penable=1, otherwise prdata=0.
REQ-016 Register map:
- 0x000 LOAD: rw, 32 bits, reset 0xFFFFFFFF.
- 0x004 VALUE: ro, current counter.
- 0x008 CTRL: rw; [0] INTEN (counter and interrupt enable), [1] RESEN; reset 0.
- 0x00C INTCLR: wo, any data.
- 0x010 RIS: ro; [0] raw interrupt.
- 0x014 MIS: ro; [0] RIS&INTEN.
- 0xFE0 ID: ro; {28'h0, ecorevnum}.
- Unmapped addresses: read 0, writes ignored.
REQ-017 A LOAD write sets LOAD and the counter to pwdata on the same edge.
REQ-018 While INTEN=1, the counter decrements by 1 per clock; while INTEN=0, it holds.
REQ-019 Timeout is defined as counter==0 with INTEN=1. On the next edge the counter reloads from LOAD and RIS is set to 1.
REQ-020 If RIS is already 1 at a timeout and RESEN=1, wdogres is set to 1 on that edge and stays 1 until apb_rst.
REQ-021 wdogint = registered RIS&INTEN; it deasserts the cycle after INTCLR or after INTEN is cleared.
REQ-022 An INTCLR write clears RIS and reloads the counter from LOAD on the same edge.
REQ-023 INTCLR coinciding with a timeout: the clear wins, RIS=0, the counter reloads and wdogres is not set.
REQ-024 A LOAD write coinciding with a timeout loads the new pwdata, and RIS is still set.
REQ-025 LOAD=0 with INTEN=1 causes a timeout every cycle.
REQ-026 Counter wrap below 0 shall never occur; a reload always precedes it.

Reset
REQ-027 On apb_rst=1 the block asynchronously applies: LOAD=0xFFFFFFFF, counter=0xFFFFFFFF, CTRL=0, RIS=0, wdogint=0, wdogres=0, lock state=unlocked.
REQ-028 Reset asserted mid-count or with wdogres=1 returns the block to the REQ-027 values; counting resumes only after INTEN is written to 1.

Configuration
REQ-029 Macro WDOG_LOCK_EN defined: adds LOCK at 0xC00.
- Writing 0x1ACCE551 unlocks; any other value locks.
- Reading returns {31'h0, locked}.
- While locked, writes to LOAD, CTRL and INTCLR are ignored.
REQ-030 Macro WDOG_LOCK_EN undefined: 0xC00 is unmapped (reads 0) and all registers are always writable.

Verification
REQ-031 Write LOAD=10, then CTRL=1 -> VALUE counts 10..0, RIS=1 and wdogint=1 one cycle after the zero count, VALUE reloads to 10.
REQ-032 Write LOAD=5 and CTRL=3, never clear -> second timeout, 12 cycles after enable, sets wdogres=1, held until apb_rst pulse.
REQ-033 Write LOAD=4 and CTRL=3, write INTCLR on the exact timeout cycle -> RIS=0, VALUE=4, wdogres stays 0.
REQ-034 With WDOG_LOCK_EN: write LOCK=0, then LOAD=0x20 -> LOAD unchanged (0xFFFFFFFF); write LOCK=0x1ACCE551, then LOAD=0x20 -> LOAD reads 0x20.
REQ-035 Assert apb_rst asynchronously mid-count with wdogint=1 -> all outputs 0 and VALUE=0xFFFFFFFF without waiting for a clock edge; read ID -> 0x0000000B with ecorevnum=4'b1011.
